// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
//
// Front end of the irrigation controller. Seven raw field lines (water-level
// probes, humidity, temperature, display selector) are each passed through a
// 2-FF synchronizer and a debounce counter, then held in a clean register.
// The clean register follows only after the synchronized line has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
//
// Optional build macro: SELECTOR_TOGGLE_EN
//   defined   - selector is a push button; its output toggles on each
//               debounced press (0->1) and ignores the release.
//   undefined - selector is a plain debounced level like the other lines.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   *_raw (7 lines)                  asynchronous field inputs
//   low/mid/high_water_level,
//   earth/air_humidity,
//   low_temperature, selector        clean registered levels
//   sensors_changed                  one-cycle pulse when any clean output changes
//   sensors_stable                   high when no channel has a pending mismatch

module sensor_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic low_water_level_raw,
    input  logic mid_water_level_raw,
    input  logic high_water_level_raw,
    input  logic earth_humidity_raw,
    input  logic air_humidity_raw,
    input  logic low_temperature_raw,
    input  logic selector_raw,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic selector,
    output logic sensors_changed,
    output logic sensors_stable
);

    localparam int N = 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: 0 low, 1 mid, 2 high, 3 earth, 4 air, 5 temp, 6 selector
    logic [N-1:0]     raw;
    logic [N-1:0]     s1_q, s1_d;
    logic [N-1:0]     s2_q, s2_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     out_q, out_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic             changed_q, changed_d;
    logic             stable_q, stable_d;

    assign raw = {selector_raw, low_temperature_raw, air_humidity_raw,
                  earth_humidity_raw, high_water_level_raw,
                  mid_water_level_raw, low_water_level_raw};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        q_d  = q_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == q_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                q_d[i]   = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        out_d = q_d;
`ifdef SELECTOR_TOGGLE_EN
        // Push-button mode: only a debounced press flips the output.
        out_d[6] = out_q[6] ^ (q_d[6] & ~q_q[6]);
`endif

        changed_d = |(out_d ^ out_q);
        // Evaluated on post-edge values so the cycle that carries the
        // change pulse already reports the channel as settled.
        stable_d  = &(s2_d ~^ q_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            q_q       <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            q_q       <= q_d;
            out_q     <= out_d;
            changed_q <= changed_d;
            stable_q  <= stable_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign low_water_level  = out_q[0];
    assign mid_water_level  = out_q[1];
    assign high_water_level = out_q[2];
    assign earth_humidity   = out_q[3];
    assign air_humidity     = out_q[4];
    assign low_temperature  = out_q[5];
    assign selector         = out_q[6];
    assign sensors_changed  = changed_q;
    assign sensors_stable   = stable_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
module tb_sensor_input_conditioner;

    localparam int D = 4;

`ifdef SELECTOR_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    // Observation vector bit positions
    localparam logic [8:0] LOW   = 9'h001;
    localparam logic [8:0] MID   = 9'h002;
    localparam logic [8:0] HIGH  = 9'h004;
    localparam logic [8:0] EARTH = 9'h008;
    localparam logic [8:0] AIR   = 9'h010;
    localparam logic [8:0] SEL   = 9'h040;
    localparam logic [8:0] OUTS  = 9'h07F;
    localparam logic [8:0] CHG   = 9'h080;
    localparam logic [8:0] STB   = 9'h100;
    localparam logic [8:0] ALL   = 9'h1FF;

    logic clk = 1'b0;
    logic reset;
    logic low_raw, mid_raw, high_raw, earth_raw, air_raw, temp_raw, sel_raw;
    logic low_water_level, mid_water_level, high_water_level;
    logic earth_humidity, air_humidity, low_temperature, selector;
    logic sensors_changed, sensors_stable;

    sensor_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk                 (clk),
        .reset               (reset),
        .low_water_level_raw (low_raw),
        .mid_water_level_raw (mid_raw),
        .high_water_level_raw(high_raw),
        .earth_humidity_raw  (earth_raw),
        .air_humidity_raw    (air_raw),
        .low_temperature_raw (temp_raw),
        .selector_raw        (sel_raw),
        .low_water_level     (low_water_level),
        .mid_water_level     (mid_water_level),
        .high_water_level    (high_water_level),
        .earth_humidity      (earth_humidity),
        .air_humidity        (air_humidity),
        .low_temperature     (low_temperature),
        .selector            (selector),
        .sensors_changed     (sensors_changed),
        .sensors_stable      (sensors_stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [8:0] v;
        logic [8:0] m;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_vec    = 0;
    int   n_err    = 0;

    task automatic push_exp(input int e, input string tag,
                            input logic [8:0] v, input logic [8:0] m);
        exp_t x;
        x.e = e; x.v = v; x.m = m; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic check_due();
        exp_t       keep[$];
        logic [8:0] obs;
        obs = {sensors_stable, sensors_changed, selector, low_temperature,
               air_humidity, earth_humidity, high_water_level,
               mid_water_level, low_water_level};
        foreach (sb[i]) begin
            if (sb[i].e == edge_cnt) begin
                n_vec++;
                assert ((obs & sb[i].m) === (sb[i].v & sb[i].m)) else begin
                    n_err++;
                    $error("FAIL %s edge %0d: observed %b expected %b (mask %b)",
                           sb[i].tag, edge_cnt, obs & sb[i].m,
                           sb[i].v & sb[i].m, sb[i].m);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            edge_cnt++;
            #1;
            check_due();
        end
    endtask

    initial begin
        int k;

        // Reset for 3 edges with every raw line high
        reset = 1'b1;
        {low_raw, mid_raw, high_raw, earth_raw, air_raw, temp_raw, sel_raw} = 7'h7F;
        for (int e = 1; e <= 3; e++) push_exp(e, "in_reset", 9'h000, ALL);
        push_exp(4, "post_rst_hold", 9'h000, OUTS | CHG);
        for (int e = 5; e <= 8; e++) push_exp(e, "post_rst_pending", 9'h000, ALL);
        push_exp(9,  "all_rise", 9'h1FF, ALL);
        push_exp(10, "all_rise_hold", 9'h17F, ALL);
        tick(3);
        reset = 1'b0;
        tick(8);

        // All lines back low together: a single change pulse
        k = edge_cnt + 1;
        {low_raw, mid_raw, high_raw, earth_raw, air_raw, temp_raw, sel_raw} = 7'h00;
        push_exp(k + 4, "all_fall_wait", OUTS, OUTS | CHG);
        push_exp(k + 5, "all_fall", (TOG ? SEL : 9'h000) | CHG | STB, ALL);
        push_exp(k + 6, "all_fall_hold", 9'h000, CHG);
        tick(8);

        // Three-cycle glitch on mid probe must not reach the output
        k = edge_cnt + 1;
        for (int j = 0; j < 8; j++) push_exp(k + j, "glitch_mid", 9'h000, MID | CHG);
        for (int j = 1; j <= 3; j++) push_exp(k + j, "glitch_unstable", 9'h000, STB);
        for (int j = 4; j <= 7; j++) push_exp(k + j, "glitch_settled", STB, STB);
        mid_raw = 1'b1;
        tick(3);
        mid_raw = 1'b0;
        tick(6);

        // Earth rises one edge before air: back-to-back change pulses
        k = edge_cnt + 1;
        push_exp(k + 4, "hum_wait", 9'h000, EARTH | AIR | CHG);
        push_exp(k + 5, "earth_up", EARTH | CHG, EARTH | AIR | CHG | STB);
        push_exp(k + 6, "air_up", EARTH | AIR | CHG | STB, EARTH | AIR | CHG | STB);
        push_exp(k + 7, "hum_hold", EARTH | AIR | STB, EARTH | AIR | CHG | STB);
        earth_raw = 1'b1;
        tick(1);
        air_raw = 1'b1;
        tick(8);
        k = edge_cnt + 1;
        push_exp(k + 4, "hum_fall_wait", EARTH | AIR, EARTH | AIR | CHG);
        push_exp(k + 5, "hum_fall", CHG | STB, EARTH | AIR | CHG | STB);
        {earth_raw, air_raw} = 2'b00;
        tick(8);

        // Reset pulse mid-debounce discards the partial count
        k = edge_cnt + 1;
        push_exp(k + 2, "high_pre_rst", 9'h000, HIGH | CHG);
        push_exp(k + 3, "high_in_rst", 9'h000, ALL);
        for (int j = 4; j <= 8; j++) push_exp(k + j, "high_after_rst", 9'h000, HIGH | CHG);
        push_exp(k + 9,  "high_up", HIGH | CHG | STB, HIGH | CHG | STB);
        push_exp(k + 10, "high_hold", HIGH, HIGH | CHG);
        high_raw = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(8);
        k = edge_cnt + 1;
        push_exp(k + 5, "high_down", CHG, HIGH | CHG);
        high_raw = 1'b0;
        tick(8);

        // Selector: two press/release cycles, 8 high then 8 low each
        k = edge_cnt + 1;
        push_exp(k + 4,  "sel_p1_wait", 9'h000, SEL | CHG);
        push_exp(k + 5,  "sel_p1", SEL | CHG, SEL | CHG);
        push_exp(k + 6,  "sel_p1_hold", SEL, SEL | CHG);
        push_exp(k + 12, "sel_r1_wait", SEL, SEL | CHG);
        push_exp(k + 13, "sel_r1", (TOG ? SEL : CHG) | STB, SEL | CHG | STB);
        push_exp(k + 20, "sel_p2_wait", TOG ? SEL : 9'h000, SEL | CHG);
        push_exp(k + 21, "sel_p2", (TOG ? 9'h000 : SEL) | CHG, SEL | CHG);
        push_exp(k + 28, "sel_r2_wait", TOG ? 9'h000 : SEL, SEL | CHG);
        push_exp(k + 29, "sel_r2", TOG ? 9'h000 : CHG, SEL | CHG);
        for (int p = 0; p < 2; p++) begin
            sel_raw = 1'b1;
            tick(8);
            sel_raw = 1'b0;
            tick(8);
        end
        tick(4);

        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expected at edge %0d, never checked (now %0d)",
                     sb[i].tag, sb[i].e, edge_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
